aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, total AES rounds; legal values 10, 12, 14; other values are unsupported.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  level request; only its rising edge launches a block operation.
REQ-005 abort  input  1  synchronous cancel of the current operation.
REQ-006 key_ready  input  1  round key for round_cnt is valid; low stalls round progress.
REQ-007 round_cnt  output  4  current round index, 0..NUM_ROUNDS; also the key-schedule index.
REQ-008 load_en  output  1  datapath loads the input block.
REQ-009 add_key_en  output  1  datapath performs AddRoundKey this cycle.
REQ-010 sub_shift_en  output  1  datapath performs SubBytes+ShiftRows this cycle.
REQ-011 mix_en  output  1  datapath performs MixColumns this cycle.
REQ-012 busy  output  1  high in LOAD, ROUND and FINAL.
REQ-013 done  output  1  single-cycle completion pulse.

Function
REQ-014 Internal edge detect: start_q registers start; start_rise = start & ~start_q; start_q updates every cycle in every state.
REQ-015 FSM states: IDLE, LOAD, ROUND, FINAL, DONE; all outputs decoded from registered state and round_cnt, plus key_ready where stated.
REQ-016 IDLE: all enables 0, busy 0, round_cnt 0; start_rise -> LOAD next cycle.
REQ-017 LOAD: one cycle; load_en=1, add_key_en=1, round_cnt=0; key_ready ignored; -> ROUND with round_cnt=1.
REQ-018 ROUND, key_ready=1: sub_shift_en=mix_en=add_key_en=1; round_cnt increments; if round_cnt==NUM_ROUNDS-1 -> FINAL, else stay in ROUND.
REQ-019 ROUND or FINAL, key_ready=0: all enables 0, state and round_cnt held, busy stays 1; stall length unbounded.
REQ-020 FINAL (round_cnt==NUM_ROUNDS), key_ready=1: sub_shift_en=1, add_key_en=1, mix_en=0; -> DONE.
REQ-021 DONE: one cycle, done=1, busy=0, enables 0, round_cnt holds NUM_ROUNDS; -> IDLE, round_cnt cleared to 0.
REQ-022 Latency with key_ready held high: done asserts NUM_ROUNDS+2 cycles after the cycle in which start_rise is sampled.
REQ-023 start_rise while in LOAD, ROUND, FINAL or DONE is dropped, not queued; start held high across completion does not relaunch.
REQ-024 abort=1 in any non-IDLE state: next state IDLE, round_cnt 0, no done pulse; abort has priority over start_rise and key_ready.
REQ-025 abort and start_rise together in IDLE: remain in IDLE.
REQ-026 round_cnt never exceeds NUM_ROUNDS; no wrap-around.
REQ-027 At most one of load_en, mix_en asserted per cycle; sub_shift_en never asserted in LOAD.

Reset
REQ-028 rst asserted: state IDLE, round_cnt 0, start_q 0, all outputs 0, immediately and independent of clk.
REQ-029 rst mid-operation aborts without done pulse; after release, start already high and sampled into start_q=0 counts as a rising edge.

Verification
REQ-030 NUM_ROUNDS=10, key_ready=1, start 0->1 at cycle 0 -> load_en at cycle 1, mix_en at cycles 2-10 with round_cnt 1..9, FINAL at cycle 11 with mix_en=0, done at cycle 12.
REQ-031 key_ready low for 3 cycles at round_cnt=5 -> enables 0, round_cnt holds 5, done delayed exactly 3 cycles (cycle 15).
REQ-032 abort at round_cnt=7 -> IDLE next cycle, round_cnt 0, busy 0, no done; new start edge then completes normally.
REQ-033 start held high through completion, then second pulse during busy -> exactly one done; new edge after IDLE -> second done.
REQ-034 NUM_ROUNDS=14 -> round_cnt reaches 14, done 16 cycles after start edge; NUM_ROUNDS=12 -> done 14 cycles after.
REQ-035 rst pulsed at round_cnt=3, released with start high -> all outputs 0 during reset, new operation starts, done 12 cycles after first post-reset edge.

Source files
------------

// File: rtl/aes_round_ctrl_if.sv
// rtl/aes_round_ctrl_if.sv - control/status bundle between the AES round sequencer and its host
`timescale 1ns/1ps

interface aes_round_ctrl_if;
  logic       start;
  logic       abort;
  logic       key_ready;
  logic [3:0] round_cnt;
  logic       load_en;
  logic       add_key_en;
  logic       sub_shift_en;
  logic       mix_en;
  logic       busy;
  logic       done;

  modport master (
    output start, abort, key_ready,
    input  round_cnt, load_en, add_key_en, sub_shift_en, mix_en, busy, done
  );

  modport slave (
    input  start, abort, key_ready,
    output round_cnt, load_en, add_key_en, sub_shift_en, mix_en, busy, done
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES round sequencer driving load/AddRoundKey/SubShift/MixColumns enables
`timescale 1ns/1ps

module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic             clk,
  input  logic             rst,
  aes_round_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] LAST_ROUND   = 4'(NUM_ROUNDS);
  localparam logic [3:0] PENULT_ROUND = 4'(NUM_ROUNDS - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] rnd;
  logic [3:0] rnd_nxt;
  logic       start_q;
  logic       start_rise;

  // Only a fresh 0->1 on start launches; a held level never relaunches.
  assign start_rise = bus.start & ~start_q;

  // Previous start level, sampled every cycle regardless of state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
    end else begin
      start_q <= bus.start;
    end
  end

  // State and round index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rnd   <= 4'd0;
    end else begin
      state <= state_nxt;
      rnd   <= rnd_nxt;
    end
  end

  // Next-state and datapath enables; key_ready gates every round-stage enable.
  always_comb begin
    state_nxt        = state;
    rnd_nxt          = rnd;
    bus.round_cnt    = rnd;
    bus.load_en      = 1'b0;
    bus.add_key_en   = 1'b0;
    bus.sub_shift_en = 1'b0;
    bus.mix_en       = 1'b0;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;

    case (state)
      IDLE: begin
        rnd_nxt = 4'd0;
        if (start_rise && !bus.abort) begin
          state_nxt = LOAD;
        end
      end

      LOAD: begin
        // Initial whitening key is applied together with the block load.
        bus.load_en    = 1'b1;
        bus.add_key_en = 1'b1;
        bus.busy       = 1'b1;
        state_nxt      = ROUND;
        rnd_nxt        = 4'd1;
      end

      ROUND: begin
        bus.busy = 1'b1;
        if (bus.key_ready) begin
          bus.sub_shift_en = 1'b1;
          bus.mix_en       = 1'b1;
          bus.add_key_en   = 1'b1;
          rnd_nxt          = rnd + 4'd1;
          if (rnd == PENULT_ROUND) begin
            state_nxt = FINAL;
          end
        end
      end

      FINAL: begin
        // Last round omits MixColumns.
        bus.busy = 1'b1;
        if (bus.key_ready) begin
          bus.sub_shift_en = 1'b1;
          bus.add_key_en   = 1'b1;
          state_nxt        = DONE;
        end
      end

      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
        rnd_nxt   = 4'd0;
      end

      default: begin
        state_nxt = IDLE;
        rnd_nxt   = 4'd0;
      end
    endcase

    // Cancel wins over everything else once an operation is under way.
    if (bus.abort && (state != IDLE)) begin
      state_nxt = IDLE;
      rnd_nxt   = 4'd0;
    end
  end

  // Round index stays within the schedule and load never overlaps MixColumns.
  assert property (@(posedge clk) disable iff (rst) rnd <= LAST_ROUND);
  assert property (@(posedge clk) disable iff (rst) !(bus.load_en && bus.mix_en));

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - scoreboard bench for aes_round_ctrl at 10, 12 and 14 rounds
`timescale 1ns/1ps

module tb_aes_round_ctrl;

  localparam int NR [3] = '{10, 12, 14};

  typedef struct {
    int         cyc;
    logic [9:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_d = 1'b1;
  logic st_d = 1'b0;
  logic ab_d = 1'b0;
  logic kr_d = 1'b1;

  int   cyc_no = 0;
  int   checks = 0;
  int   errors = 0;
  int   ph [3];
  logic prev_st;
  int   exp_dones [3];
  int   act_dones [3];
  exp_t exp_q [3][$];
  logic [9:0] obs [3];

  always #5 clk = ~clk;

  aes_round_ctrl_if bus0 ();
  aes_round_ctrl_if bus1 ();
  aes_round_ctrl_if bus2 ();

  assign bus0.start = st_d;  assign bus0.abort = ab_d;  assign bus0.key_ready = kr_d;
  assign bus1.start = st_d;  assign bus1.abort = ab_d;  assign bus1.key_ready = kr_d;
  assign bus2.start = st_d;  assign bus2.abort = ab_d;  assign bus2.key_ready = kr_d;

  aes_round_ctrl #(.NUM_ROUNDS(10)) dut0 (.clk(clk), .rst(rst_d), .bus(bus0.slave));
  aes_round_ctrl #(.NUM_ROUNDS(12)) dut1 (.clk(clk), .rst(rst_d), .bus(bus1.slave));
  aes_round_ctrl #(.NUM_ROUNDS(14)) dut2 (.clk(clk), .rst(rst_d), .bus(bus2.slave));

  assign obs[0] = {bus0.round_cnt, bus0.load_en, bus0.add_key_en, bus0.sub_shift_en, bus0.mix_en, bus0.busy, bus0.done};
  assign obs[1] = {bus1.round_cnt, bus1.load_en, bus1.add_key_en, bus1.sub_shift_en, bus1.mix_en, bus1.busy, bus1.done};
  assign obs[2] = {bus2.round_cnt, bus2.load_en, bus2.add_key_en, bus2.sub_shift_en, bus2.mix_en, bus2.busy, bus2.done};

  // Progress p: -1 idle, 0 loading, 1..n working on round p (n = last round), n+1 reporting done.
  function automatic logic [9:0] model_out(input int p, input int n, input logic kr);
    logic [3:0] rc;
    logic ld, ak, ss, mx, bz, dn;
    rc = 4'd0; ld = 1'b0; ak = 1'b0; ss = 1'b0; mx = 1'b0; bz = 1'b0; dn = 1'b0;
    if (p == 0) begin
      ld = 1'b1; ak = 1'b1; bz = 1'b1;
    end else if (p >= 1 && p <= n) begin
      bz = 1'b1;
      rc = 4'(p);
      if (kr) begin
        ak = 1'b1; ss = 1'b1; mx = (p < n);
      end
    end else if (p == n + 1) begin
      dn = 1'b1;
      rc = 4'(n);
    end
    return {rc, ld, ak, ss, mx, bz, dn};
  endfunction

  function automatic int model_next(input int p, input int n, input logic rise,
                                    input logic ab, input logic kr);
    if (p < 0) return (rise && !ab) ? 0 : -1;
    if (ab) return -1;
    if (p <= n) return (p == 0 || kr) ? p + 1 : p;
    return -1;
  endfunction

  // One clock cycle: retire the model on the edge, then apply the new inputs and queue expectations.
  task automatic drive(input logic st, input logic ab, input logic kr, input logic rs);
    logic [9:0] v;
    @(posedge clk);
    if (rst_d) begin
      for (int i = 0; i < 3; i++) ph[i] = -1;
      prev_st = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) ph[i] = model_next(ph[i], NR[i], st_d & ~prev_st, ab_d, kr_d);
      prev_st = st_d;
    end
    cyc_no++;
    #1;
    st_d = st; ab_d = ab; kr_d = kr; rst_d = rs;
    if (rs) begin
      for (int i = 0; i < 3; i++) ph[i] = -1;
      prev_st = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== 10'd0) begin
          errors++;
          $display("FAIL reset_outputs n=%0d cycle %0d: actual %b required %b", NR[i], cyc_no, obs[i], 10'd0);
        end
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        v = model_out(ph[i], NR[i], kr);
        if (v != 10'd0) begin
          exp_q[i].push_back('{cyc: cyc_no, v: v});
          if (v[0]) exp_dones[i]++;
        end
      end
    end
  endtask

  // Monitor: any cycle with an expectation or a non-quiet DUT output is compared.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (obs[i][0] === 1'b1) act_dones[i]++;
      if (exp_q[i].size() != 0 && exp_q[i][0].cyc == cyc_no) begin
        e = exp_q[i].pop_front();
        checks++;
        if (obs[i] !== e.v) begin
          errors++;
          $display("FAIL outputs n=%0d cycle %0d: actual rc/ld/ak/ss/mx/bz/dn=%b required %b", NR[i], cyc_no, obs[i], e.v);
        end
      end else if (obs[i] !== 10'd0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_activity n=%0d cycle %0d: actual %b required %b", NR[i], cyc_no, obs[i], 10'd0);
      end
    end
  end

  initial begin
    logic st, ab, kr, rs;
    for (int i = 0; i < 3; i++) begin
      ph[i] = -1; exp_dones[i] = 0; act_dones[i] = 0;
    end
    prev_st = 1'b0;

    drive(0, 0, 1, 1);
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);

    // Start held high across completion, then a second launch with an extra pulse while busy.
    repeat (21) drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(1, 0, 1, 0);
    repeat (20) drive(0, 0, 1, 0);

    // Key stall of three cycles mid-operation.
    drive(1, 0, 1, 0);
    repeat (6) drive(0, 0, 1, 0);
    repeat (3) drive(0, 0, 0, 0);
    repeat (20) drive(0, 0, 1, 0);

    // Abort mid-operation, then a clean relaunch; abort coinciding with a start edge in idle.
    drive(1, 0, 1, 0);
    repeat (8) drive(0, 0, 1, 0);
    drive(0, 1, 1, 0);
    drive(0, 0, 1, 0);
    drive(1, 1, 1, 0);
    drive(0, 0, 1, 0);
    drive(1, 0, 1, 0);
    repeat (20) drive(0, 0, 1, 0);

    // Reset mid-operation, released with start still high.
    drive(1, 0, 1, 0);
    repeat (4) drive(1, 0, 1, 0);
    repeat (2) drive(1, 0, 1, 1);
    repeat (20) drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);

    // Randomized traffic.
    repeat (3000) begin
      st = (($urandom % 6) == 0) ? ~st_d : st_d;
      ab = (($urandom % 50) == 0);
      kr = (($urandom % 4) != 0);
      rs = (($urandom % 400) == 0);
      drive(st, ab, kr, rs);
    end
    repeat (20) drive(0, 0, 1, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL pending_expectations n=%0d: actual %0d left required 0", NR[i], exp_q[i].size());
      end
      checks++;
      if (act_dones[i] != exp_dones[i]) begin
        errors++;
        $display("FAIL done_count n=%0d: actual %0d required %0d", NR[i], act_dones[i], exp_dones[i]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
